// File: rtl/xeq_activity_pipe_pkg.sv
// Shared defaults and mode encoding for the XOR-equality activity pipe.
// Imported by the lane and the top.
package xeq_activity_pipe_pkg;

   localparam int XEQ_W     = 8;
   localparam int XEQ_CH    = 4;
   localparam int XEQ_CNT_W = 16;

   typedef enum logic {
      MODE_DIFF_EQ = 1'b0,
      MODE_EQ_DIFF = 1'b1
   } mode_e;

endpackage

// File: rtl/xeq_activity_pipe_lane.sv
// One channel: per-bit result from the stage-1 XOR terms, and the
// number of bits that flip between the last two transferred outputs.
module xeq_lane
   import xeq_activity_pipe_pkg::*;
#(
   parameter int W  = XEQ_W,
   parameter int PW = $clog2(W + 1)
) (
   input  logic          mode_i,
   input  logic [W-1:0]  ab_i,
   input  logic [W-1:0]  cd_i,
   input  logic [W-1:0]  cur_i,
   input  logic [W-1:0]  prev_i,
   output logic [W-1:0]  res_o,
   output logic [PW-1:0] pop_o
);

   logic [W-1:0] diff;

   always_comb begin
      res_o = '0;
      unique case (mode_i)
         MODE_DIFF_EQ: res_o = cd_i & ~ab_i;
         MODE_EQ_DIFF: res_o = ab_i & ~cd_i;
         default:      res_o = '0;
      endcase
   end

   assign diff = cur_i ^ prev_i;

   always_comb begin
      pop_o = '0;
      for (int i = 0; i < W; i++) begin
         pop_o = pop_o + {{(PW-1){1'b0}}, diff[i]};
      end
   end

endmodule

// File: rtl/xeq_activity_pipe.sv
// Two-stage valid/ready pipe computing XOR-equality masks per channel,
// with saturating per-channel output toggle counters.
module xeq_activity_pipe
   import xeq_activity_pipe_pkg::*;
#(
   parameter int W     = XEQ_W,
   parameter int CH    = XEQ_CH,
   parameter int CNT_W = XEQ_CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH*W-1:0]     a,
   input  logic [CH*W-1:0]     b,
   input  logic [CH*W-1:0]     c,
   input  logic [CH*W-1:0]     d,
   input  logic                mode,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [CH*W-1:0]     out_bits,
   output logic [CH-1:0]       out_any,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                cnt_clr,
   output logic [CH*CNT_W-1:0] toggle_cnt
);

   localparam int N  = CH * W;
   localparam int PW = $clog2(W + 1);

   logic s1_v_q, s1_v_d;
   logic s2_v_q, s2_v_d;
   logic s1_load, s2_load, s2_fire;

   logic [N-1:0] ab_q, cd_q;
   logic         mode_q;
   logic [N-1:0] bits_q, prev_q, prev_d;
   logic [CH-1:0] any_q, any_d;
   logic [CH*CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     res;
   logic [CH*PW-1:0] pop;

   // Single shared occupancy control: a stage loads when empty or draining.
   assign s2_fire  = s2_v_q & out_ready;
   assign s2_load  = s1_v_q & (~s2_v_q | out_ready);
   assign in_ready = ~s1_v_q | s2_load;
   assign s1_load  = in_valid & in_ready;

   always_comb begin
      s1_v_d = s1_v_q;
      s2_v_d = s2_v_q;
      if (s1_load)
         s1_v_d = 1'b1;
      else if (s2_load)
         s1_v_d = 1'b0;
      if (s2_load)
         s2_v_d = 1'b1;
      else if (s2_fire)
         s2_v_d = 1'b0;
   end

   assign prev_d = s2_fire ? bits_q : prev_q;

   for (genvar k = 0; k < CH; k++) begin : g_lane
      logic [CNT_W:0] sum;

      xeq_lane #(
         .W  (W),
         .PW (PW)
      ) u_lane (
         .mode_i (mode_q),
         .ab_i   (ab_q[k*W +: W]),
         .cd_i   (cd_q[k*W +: W]),
         .cur_i  (bits_q[k*W +: W]),
         .prev_i (prev_q[k*W +: W]),
         .res_o  (res[k*W +: W]),
         .pop_o  (pop[k*PW +: PW])
      );

      assign any_d[k] = |res[k*W +: W];

      // One spare bit catches overflow so the counter pins at all-ones.
      assign sum = {1'b0, cnt_q[k*CNT_W +: CNT_W]}
                 + {{(CNT_W+1-PW){1'b0}}, pop[k*PW +: PW]};

      assign cnt_d[k*CNT_W +: CNT_W] =
         cnt_clr  ? {CNT_W{1'b0}} :
         !s2_fire ? cnt_q[k*CNT_W +: CNT_W] :
         sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         ab_q   <= '0;
         cd_q   <= '0;
         mode_q <= 1'b0;
         bits_q <= '0;
         any_q  <= '0;
         prev_q <= '0;
         cnt_q  <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
         if (s1_load) begin
            ab_q   <= a ^ b;
            cd_q   <= c ^ d;
            mode_q <= mode;
         end
         if (s2_load) begin
            bits_q <= res;
            any_q  <= any_d;
         end
      end
   end

   assign out_valid  = s2_v_q;
   assign out_bits   = bits_q;
   assign out_any    = any_q;
   assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_xeq_activity_pipe.sv
// Directed bench for xeq_activity_pipe (W=8, CH=2, CNT_W=4).
module tb_xeq_activity_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a, b, c, d;
   logic        mode, in_valid, in_ready;
   logic [15:0] out_bits;
   logic [1:0]  out_any;
   logic        out_valid, out_ready, cnt_clr;
   logic [7:0]  toggle_cnt;

   int pass_n = 0;
   int tot_n  = 0;

   xeq_activity_pipe #(
      .W     (8),
      .CH    (2),
      .CNT_W (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .mode       (mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_bits   (out_bits),
      .out_any    (out_any),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .cnt_clr    (cnt_clr),
      .toggle_cnt (toggle_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      mode      = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic send_one(input logic m, input logic [15:0] va,
                           input logic [15:0] vb, input logic [15:0] vc,
                           input logic [15:0] vd);
      logic acc;
      acc = 1'b0;
      mode = m; a = va; b = vb; c = vc; d = vd;
      in_valid = 1'b1;
      for (int i = 0; i < 10 && !acc; i++) begin
         #1;
         acc = in_ready;
         tick;
      end
      in_valid = 1'b0;
      tot_n++;
      if (acc !== 1'b1)
         $display("FAIL send_accept: got %b want 1", acc);
      else
         pass_n++;
   endtask

   task automatic test_reset;
      tick;
      tot_n++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
      else pass_n++;
      tot_n++;
      if (out_bits !== 16'h0) $display("FAIL rst_out_bits: got %h want 0000", out_bits);
      else pass_n++;
      tot_n++;
      if (out_any !== 2'b00) $display("FAIL rst_out_any: got %b want 00", out_any);
      else pass_n++;
      tot_n++;
      if (toggle_cnt !== 8'h00) $display("FAIL rst_cnt: got %h want 00", toggle_cnt);
      else pass_n++;
      do_reset;
      #1;
      tot_n++;
      if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
      else pass_n++;
   endtask

   task automatic test_mode0;
      do_reset;
      send_one(1'b0, 16'h0100, 16'h0100, 16'h3C0F, 16'h0F00);
      tot_n++;
      if (out_valid !== 1'b0) $display("FAIL m0_lat1: got %b want 0", out_valid);
      else pass_n++;
      tick;
      tot_n++;
      if (out_valid !== 1'b1) $display("FAIL m0_lat2: got %b want 1", out_valid);
      else pass_n++;
      tot_n++;
      if (out_bits !== 16'h330F) $display("FAIL m0_bits: got %h want 330f", out_bits);
      else pass_n++;
      tot_n++;
      if (out_any !== 2'b11) $display("FAIL m0_any: got %b want 11", out_any);
      else pass_n++;
      tick;
      tot_n++;
      if (out_valid !== 1'b0) $display("FAIL m0_drain: got %b want 0", out_valid);
      else pass_n++;
      tot_n++;
      if (toggle_cnt !== 8'h44) $display("FAIL m0_cnt: got %h want 44", toggle_cnt);
      else pass_n++;
   endtask

   task automatic test_mode1_back_to_back;
      do_reset;
      mode = 1'b1;
      a = 16'h0FF0; b = 16'h0000; c = 16'h55AA; d = 16'h50AA;
      in_valid = 1'b1;
      #1;
      tot_n++;
      if (in_ready !== 1'b1) $display("FAIL m1_rdy0: got %b want 1", in_ready);
      else pass_n++;
      tick;
      b = 16'h0FF0;
      #1;
      tot_n++;
      if (in_ready !== 1'b1) $display("FAIL m1_rdy1: got %b want 1", in_ready);
      else pass_n++;
      tick;
      in_valid = 1'b0;
      tot_n++;
      if (out_bits !== 16'h0AF0) $display("FAIL m1_bits1: got %h want 0af0", out_bits);
      else pass_n++;
      tot_n++;
      if (out_any !== 2'b11) $display("FAIL m1_any1: got %b want 11", out_any);
      else pass_n++;
      tick;
      tot_n++;
      if (out_valid !== 1'b1) $display("FAIL m1_valid2: got %b want 1", out_valid);
      else pass_n++;
      tot_n++;
      if (out_bits !== 16'h0000) $display("FAIL m1_bits2: got %h want 0000", out_bits);
      else pass_n++;
      tot_n++;
      if (out_any !== 2'b00) $display("FAIL m1_any2: got %b want 00", out_any);
      else pass_n++;
      tot_n++;
      if (toggle_cnt !== 8'h24) $display("FAIL m1_cnt1: got %h want 24", toggle_cnt);
      else pass_n++;
      tick;
      tot_n++;
      if (toggle_cnt !== 8'h48) $display("FAIL m1_cnt2: got %h want 48", toggle_cnt);
      else pass_n++;
      tot_n++;
      if (out_valid !== 1'b0) $display("FAIL m1_drain: got %b want 0", out_valid);
      else pass_n++;
   endtask

   task automatic test_stream;
      logic [15:0] q[$];
      logic [15:0] exp_v;
      logic [7:0]  hi;
      int sent, got;
      logic acc, fire;
      sent = 0;
      got  = 0;
      do_reset;
      mode = 1'b1;
      b = 16'h0F00; c = 16'h0; d = 16'h0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 6);
         hi = 8'(sent * 17);
         a = {hi, 8'(sent)};
         in_valid = (sent < 10);
         #1;
         if (in_valid) begin
            tot_n++;
            if (in_ready !== out_ready)
               $display("FAIL st_in_ready c%0d: got %b want %b", cyc, in_ready, out_ready);
            else
               pass_n++;
         end
         acc  = in_valid && in_ready;
         fire = out_valid && out_ready;
         if (fire) begin
            exp_v = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
            tot_n++;
            if (out_bits !== exp_v)
               $display("FAIL st_data n%0d: got %h want %h", got, out_bits, exp_v);
            else
               pass_n++;
            got++;
         end
         if (acc) begin
            q.push_back({hi ^ 8'h0F, 8'(sent)});
            sent++;
         end
         tick;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tot_n++;
      if (got != 10) $display("FAIL st_count: got %0d want 10", got);
      else pass_n++;
   endtask

   task automatic test_saturate;
      logic [7:0] exp_c [3];
      exp_c[0] = 8'h88;
      exp_c[1] = 8'hFF;
      exp_c[2] = 8'hFF;
      do_reset;
      for (int k = 0; k < 3; k++) begin
         if (k % 2 == 0)
            send_one(1'b1, 16'hFFFF, 16'h0000, 16'h0, 16'h0);
         else
            send_one(1'b1, 16'h0000, 16'h0000, 16'h0, 16'h0);
         tick;
         tot_n++;
         if (out_valid !== 1'b1) $display("FAIL sat_valid%0d: got %b want 1", k, out_valid);
         else pass_n++;
         tick;
         tot_n++;
         if (toggle_cnt !== exp_c[k])
            $display("FAIL sat_cnt%0d: got %h want %h", k, toggle_cnt, exp_c[k]);
         else
            pass_n++;
      end
   endtask

   task automatic test_clear;
      do_reset;
      send_one(1'b1, 16'hFFFF, 16'h0000, 16'h0, 16'h0);
      tick;
      tick;
      tot_n++;
      if (toggle_cnt !== 8'h88) $display("FAIL clr_pre: got %h want 88", toggle_cnt);
      else pass_n++;
      send_one(1'b1, 16'h0000, 16'h0000, 16'h0, 16'h0);
      tick;
      cnt_clr = 1'b1;
      tick;
      cnt_clr = 1'b0;
      tot_n++;
      if (toggle_cnt !== 8'h00) $display("FAIL clr_hit: got %h want 00", toggle_cnt);
      else pass_n++;
      tot_n++;
      if (out_valid !== 1'b0) $display("FAIL clr_xfer: got %b want 0", out_valid);
      else pass_n++;
      send_one(1'b1, 16'hFFFF, 16'h0000, 16'h0, 16'h0);
      tick;
      tick;
      tot_n++;
      if (toggle_cnt !== 8'h88) $display("FAIL clr_prev: got %h want 88", toggle_cnt);
      else pass_n++;
      cnt_clr = 1'b1;
      tick;
      cnt_clr = 1'b0;
      tot_n++;
      if (toggle_cnt !== 8'h00) $display("FAIL clr_idle: got %h want 00", toggle_cnt);
      else pass_n++;
   endtask

   task automatic test_reset_mid;
      int seen;
      seen = 0;
      do_reset;
      send_one(1'b1, 16'hFFFF, 16'h0000, 16'h0, 16'h0);
      tick;
      tick;
      out_ready = 1'b0;
      send_one(1'b1, 16'h00F0, 16'h0000, 16'h0, 16'h0);
      send_one(1'b1, 16'h0F00, 16'h0000, 16'h0, 16'h0);
      #1;
      tot_n++;
      if (in_ready !== 1'b0) $display("FAIL rm_full_rdy: got %b want 0", in_ready);
      else pass_n++;
      tot_n++;
      if (out_bits !== 16'h00F0) $display("FAIL rm_held: got %h want 00f0", out_bits);
      else pass_n++;
      #2;
      rst_n = 1'b0;
      #1;
      tot_n++;
      if (out_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", out_valid);
      else pass_n++;
      tot_n++;
      if (toggle_cnt !== 8'h00) $display("FAIL rm_cnt: got %h want 00", toggle_cnt);
      else pass_n++;
      tot_n++;
      if (out_bits !== 16'h0000) $display("FAIL rm_bits: got %h want 0000", out_bits);
      else pass_n++;
      tick;
      tick;
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      tot_n++;
      if (in_ready !== 1'b1) $display("FAIL rm_rdy: got %b want 1", in_ready);
      else pass_n++;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (out_valid) seen++;
      end
      tot_n++;
      if (seen != 0) $display("FAIL rm_ghost: got %0d want 0", seen);
      else pass_n++;
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; mode = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      test_reset;
      test_mode0;
      test_mode1_back_to_back;
      test_stream;
      test_saturate;
      test_clear;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/xeq_activity_pipe.md
XEQ_ACTIVITY_PIPE -- requirements
Module: xeq_activity_pipe

Interface
REQ-001 SHALL have parameter W, default 8: bits per channel word.
REQ-002 SHALL have parameter CH, default 4: number of independent channels.
REQ-003 SHALL have parameter CNT_W, default 16: width of each per-channel toggle counter.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports a, b, c, d  in  CH*W each  operand words; channel k occupies bits [k*W +: W].
REQ-007 SHALL have port mode  in  1  function select; sampled with each accepted input.
REQ-008 SHALL have port in_valid  in  1 and in_ready  out  1  input handshake.
REQ-009 SHALL have port out_bits  out  CH*W  registered per-bit result.
REQ-010 SHALL have port out_any  out  CH  per-channel OR-reduce of out_bits.
REQ-011 SHALL have port out_valid  out  1 and out_ready  in  1  output handshake.
REQ-012 SHALL have port cnt_clr  in  1  synchronous clear of all toggle counters.
REQ-013 SHALL have port toggle_cnt  out  CH*CNT_W  per-channel output-activity counters.

Function
REQ-014 mode=0: out_bits bit i SHALL equal (c_i XOR d_i) AND NOT(a_i XOR b_i).
REQ-015 mode=1: out_bits bit i SHALL equal (a_i XOR b_i) AND NOT(c_i XOR d_i).
REQ-016 Transfer SHALL occur on a cycle where valid and ready are both 1; data is unchanged while valid=1 and ready=0.
REQ-017 Pipeline SHALL have two register stages: S1 holds XOR terms and mode, S2 holds out_bits/out_any.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid=1 when out_ready stays 1.
REQ-019 Each stage SHALL load when empty or when its contents leave in the same cycle; in_ready = NOT S1-full OR S1 advancing.
REQ-020 With out_ready held 1, one transfer per cycle SHALL be sustained (full throughput, no bubbles).
REQ-021 With out_ready=0, at most 2 items SHALL be buffered; in_ready SHALL drop to 0 the cycle after both stages are full; no item lost or duplicated.
REQ-022 On each output transfer, toggle_cnt[k] SHALL increase by popcount(out_bits_k XOR prev_k), prev_k then updated to out_bits_k.
REQ-023 toggle_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 cnt_clr=1 SHALL zero all counters next edge; cnt_clr coincident with an output transfer: counter = 0, prev_k still updated.
REQ-025 cnt_clr SHALL NOT affect pipeline data or handshakes.
REQ-026 out_any[k] SHALL be registered alongside out_bits, never combinational from inputs.

Reset
REQ-027 rst_n low SHALL immediately force: S1/S2 empty, out_valid=0, out_bits=0, out_any=0, toggle_cnt=0, prev_k=0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-029 Reset mid-operation SHALL discard in-flight items; no output transfer follows for them.

Structure
REQ-030 Shared package SHALL hold default W/CH/CNT_W and a mode enum (MODE_DIFF_EQ=0, MODE_EQ_DIFF=1).
REQ-031 One sub-module xeq_lane SHALL compute one channel's W-bit result and toggle popcount; instantiated CH times.
REQ-032 Handshake/stage-occupancy control SHALL be a single shared instance, not per lane.

Verification
REQ-033 W=8,CH=1, mode=0, a=b=0x00, c=0x0F, d=0x00 -> out_bits=0x0F, out_any=1, out_valid 2 cycles after accept.
REQ-034 mode=1, a=0xF0,b=0x00,c=d=0xAA -> out_bits=0xF0; then a=b -> out_bits=0x00, out_any=0, toggle_cnt=4+4=8.
REQ-035 Stream 10 items, out_ready=0 cycles 3-6 -> in_ready=0 after 2 buffered, all 10 outputs in order, none repeated.
REQ-036 CNT_W=4, alternate out_bits 0x00/0xFF 3 transfers -> counter 8 then 15 (saturated), held at 15.
REQ-037 cnt_clr asserted same cycle as a transfer with 8 toggles -> toggle_cnt=0; next toggling transfer counts from prev.
REQ-038 rst_n low while both stages full -> out_valid=0 asynchronously, counters 0, in_ready=1 after release.
